// File: rtl/tcdm_mem_pkg.sv
// tcdm_mem_pkg: response type, LFSR constants and address-range helper for tcdm_mem_model
package tcdm_mem_pkg;
  localparam int TCDM_DW = 32;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  typedef struct packed {
    logic valid;
    logic opc;
    logic [TCDM_DW-1:0] rdata;
  } resp_t;
  function automatic logic addr_in_range(input logic [63:0] a, input logic [63:0] base, input logic [63:0] span);
    return (a >= base) && ((a - base) < span);
  endfunction
endpackage

// File: rtl/tcdm_stall_gen.sv
// tcdm_stall_gen: per-port pseudo-random grant stall, capped at MAX_STALL consecutive cycles
module tcdm_stall_gen import tcdm_mem_pkg::*; #(
  parameter int MAX_STALL = 7,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_stall_thr,
  input  logic       i_req,
  output logic       o_stall
);
  localparam int CW = ($clog2(MAX_STALL + 1) > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? 16'h0001 : SEED;
  logic [LFSR_W-1:0] r_lfsr;
  logic [CW-1:0] r_cnt;
  assign o_stall = (r_lfsr[7:0] < i_stall_thr) && (r_cnt < CW'(MAX_STALL));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED_NZ;
      r_cnt  <= '0;
    end else begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
      r_cnt  <= (i_req && o_stall) ? r_cnt + 1'b1 : '0;
    end
  end
endmodule

// File: rtl/tcdm_mem_model.sv
// tcdm_mem_model: multi-port TCDM slave memory with fixed response latency.
// Define TCDM_MEM_STALL_EN to compile in the per-port random grant-stall generator.
module tcdm_mem_model import tcdm_mem_pkg::*; #(
  parameter int NB_PORTS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = TCDM_DW,
  parameter int DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h1C00_0000,
  parameter int RESP_LATENCY = 1,
  parameter int MAX_STALL = 7,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [7:0]                             i_stall_thr,
  input  logic [NB_PORTS-1:0]                    i_req,
  input  logic [NB_PORTS-1:0][ADDR_WIDTH-1:0]    i_addr,
  input  logic [NB_PORTS-1:0]                    i_wen,
  input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0]    i_wdata,
  input  logic [NB_PORTS-1:0][DATA_WIDTH/8-1:0]  i_be,
  output logic [NB_PORTS-1:0]                    o_gnt,
  output logic [NB_PORTS-1:0]                    o_r_valid,
  output logic [NB_PORTS-1:0][DATA_WIDTH-1:0]    o_r_rdata,
  output logic [NB_PORTS-1:0]                    o_r_opc
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int OFS = $clog2(BW);
  localparam int IW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  resp_t r_pipe [NB_PORTS][RESP_LATENCY];
  resp_t w_pin [NB_PORTS][RESP_LATENCY];
  logic [NB_PORTS-1:0] w_stall, w_hit;
  logic [NB_PORTS-1:0][IW-1:0] w_idx;
`ifdef TCDM_MEM_STALL_EN
  for (genvar p = 0; p < NB_PORTS; p++) begin : g_stall
    tcdm_stall_gen #(.MAX_STALL(MAX_STALL), .SEED(SEED ^ LFSR_W'(p))) u_stall (
      .clk(clk), .rst_n(rst_n), .i_stall_thr(i_stall_thr), .i_req(i_req[p]), .o_stall(w_stall[p])
    );
  end
`else
  logic w_unused_thr;
  assign w_unused_thr = ^i_stall_thr;
  assign w_stall = '0;
`endif
  assign o_gnt = i_req & ~w_stall;
  // Stage 0 samples the array before this edge's writes land, giving read-before-write
  always_comb begin
    for (int p = 0; p < NB_PORTS; p++) begin
      w_hit[p] = addr_in_range(64'(i_addr[p]), 64'(BASE_ADDR), 64'(DEPTH) * 64'(BW));
      w_idx[p] = IW'((i_addr[p] - BASE_ADDR) >> OFS);
      w_pin[p][0] = '{valid: o_gnt[p], opc: o_gnt[p] & ~w_hit[p],
                      rdata: (o_gnt[p] && w_hit[p] && i_wen[p]) ? r_mem[w_idx[p]] : '0};
      for (int s = 1; s < RESP_LATENCY; s++) w_pin[p][s] = r_pipe[p][s-1];
      o_r_valid[p] = r_pipe[p][RESP_LATENCY-1].valid;
      o_r_opc[p]   = r_pipe[p][RESP_LATENCY-1].opc;
      o_r_rdata[p] = r_pipe[p][RESP_LATENCY-1].rdata;
    end
  end
  // Last stage only loads data on a valid response so rdata/opc hold between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      for (int p = 0; p < NB_PORTS; p++)
        for (int s = 0; s < RESP_LATENCY; s++) r_pipe[p][s] <= '0;
    end else begin
      for (int p = 0; p < NB_PORTS; p++)
        for (int s = 0; s < RESP_LATENCY; s++)
          if (s < RESP_LATENCY - 1 || w_pin[p][s].valid) r_pipe[p][s] <= w_pin[p][s];
          else r_pipe[p][s].valid <= 1'b0;
      for (int p = 0; p < NB_PORTS; p++)
        if (o_gnt[p] && w_hit[p] && !i_wen[p])
          for (int b = 0; b < BW; b++)
            if (i_be[p][b]) r_mem[w_idx[p]][b*8 +: 8] <= i_wdata[p][b*8 +: 8];
    end
  end
endmodule

// File: tb/tb_tcdm_mem_model.sv
// tb_tcdm_mem_model: table-driven checks with a per-port response scoreboard, plus latency-4 reset sequence
module tb_tcdm_mem_model;
  localparam int NP = 4;
  localparam logic [31:0] BASE = 32'h1C00_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst4_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] stall_thr = 8'h00;
  logic [7:0] stall4 = 8'h00;
  logic [NP-1:0] req = '0, wen = '0, gnt, r_valid, r_opc;
  logic [NP-1:0][31:0] addr = '0, wdata = '0, r_rdata;
  logic [NP-1:0][3:0] be = '0;
  logic [0:0] req4 = '0, wen4 = '0, gnt4, rv4, opc4;
  logic [0:0][31:0] addr4 = '0, wdata4 = '0, rd4;
  logic [0:0][3:0] be4 = '0;
  tcdm_mem_model u_dut (
    .clk(clk), .rst_n(rst_n), .i_stall_thr(stall_thr), .i_req(req), .i_addr(addr), .i_wen(wen),
    .i_wdata(wdata), .i_be(be), .o_gnt(gnt), .o_r_valid(r_valid), .o_r_rdata(r_rdata), .o_r_opc(r_opc)
  );
  tcdm_mem_model #(.NB_PORTS(1), .DEPTH(64), .RESP_LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .i_stall_thr(stall4), .i_req(req4), .i_addr(addr4), .i_wen(wen4),
    .i_wdata(wdata4), .i_be(be4), .o_gnt(gnt4), .o_r_valid(rv4), .o_r_rdata(rd4), .o_r_opc(opc4)
  );
  typedef struct {logic [31:0] rdata; logic opc; int cyc;} exp_t;
  typedef struct {int port; logic w; logic [31:0] a; logic [31:0] d; logic [3:0] b; logic [31:0] er; logic eo;} vec_t;
  exp_t exp_q[NP][$];
  exp_t e_m;
  vec_t vt[$];
  logic [NP-1:0][31:0] e_rdata = '0;
  logic [NP-1:0] e_opc = '0;
  int cyc = 0, n_tests = 0, n_fail = 0;
  int ng, gap, maxgap;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic setp(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic [31:0] er, input logic eo);
    req[p] = 1'b1; wen[p] = ~w; addr[p] = a; wdata[p] = d; be[p] = b; e_rdata[p] = er; e_opc[p] = eo;
  endtask
  task automatic lat4(input logic [31:0] er);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req4 = '0;
      chk($sformatf("l4_valid_k%0d", k), 32'(rv4), 32'(k == 4));
      if (k == 4) begin
        chk("l4_rdata", rd4[0], er);
        chk("l4_opc", 32'(opc4), 0);
      end
    end
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n)
      for (int p = 0; p < NP; p++)
        if (req[p] && gnt[p]) exp_q[p].push_back('{e_rdata[p], e_opc[p], cyc});
  end
  always @(negedge clk) begin
    if (rst_n)
      for (int p = 0; p < NP; p++)
        if (r_valid[p]) begin
          n_tests++;
          if (exp_q[p].size() == 0) begin
            n_fail++;
            $display("FAIL resp_p%0d: unexpected response rdata %h opc %0b", p, r_rdata[p], r_opc[p]);
          end else begin
            e_m = exp_q[p].pop_front();
            if (r_rdata[p] !== e_m.rdata || r_opc[p] !== e_m.opc || cyc != e_m.cyc + 1) begin
              n_fail++;
              $display("FAIL resp_p%0d: got rdata %h opc %0b at cycle %0d, expected rdata %h opc %0b at cycle %0d",
                       p, r_rdata[p], r_opc[p], cyc, e_m.rdata, e_m.opc, e_m.cyc + 1);
            end
          end
        end
  end
  initial begin
    req = 4'b1010;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0000_000A);
    chk("rst_valid", 32'(r_valid), 0);
    chk("rst_rdata0", r_rdata[0], 0);
    chk("rst_opc", 32'(r_opc), 0);
    req = '0;
    rst_n = 1'b1;
    rst4_n = 1'b1;
    vt.push_back('{0, 1'b1, BASE + 32'h10,   32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0});
    vt.push_back('{0, 1'b0, BASE + 32'h10,   32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0});
    vt.push_back('{1, 1'b1, BASE + 32'h20,   32'h1122_3344, 4'hF, 32'h0,         1'b0});
    vt.push_back('{1, 1'b1, BASE + 32'h20,   32'hAAAA_AAAA, 4'h5, 32'h0,         1'b0});
    vt.push_back('{2, 1'b0, BASE + 32'h20,   32'h0,         4'hF, 32'h11AA_33AA, 1'b0});
    vt.push_back('{0, 1'b0, BASE + 32'h1000, 32'h0,         4'hF, 32'h0,         1'b1});
    vt.push_back('{3, 1'b1, BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1});
    vt.push_back('{0, 1'b0, BASE,            32'h0,         4'hF, 32'h0,         1'b0});
    vt.push_back('{2, 1'b1, BASE + 32'h24,   32'h5555_5555, 4'h0, 32'h0,         1'b0});
    vt.push_back('{2, 1'b0, BASE + 32'h24,   32'h0,         4'hF, 32'h0,         1'b0});
    vt.push_back('{1, 1'b0, BASE - 32'h4,    32'h0,         4'hF, 32'h0,         1'b1});
    vt.push_back('{3, 1'b1, BASE + 32'hFFC,  32'h1234_5678, 4'hF, 32'h0,         1'b0});
    vt.push_back('{3, 1'b0, BASE + 32'hFFC,  32'h0,         4'hF, 32'h1234_5678, 1'b0});
    vt.push_back('{2, 1'b0, BASE + 32'h10,   32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0});
    vt.push_back('{0, 1'b0, BASE + 32'h13,   32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0});
    foreach (vt[i]) begin
      @(negedge clk);
      req = '0;
      setp(vt[i].port, vt[i].w, vt[i].a, vt[i].d, vt[i].b, vt[i].er, vt[i].eo);
      #1 chk($sformatf("gnt_v%0d", i), 32'(gnt), 32'(req));
    end
    @(negedge clk);
    req = '0;
    @(negedge clk);
    chk("hold_valid", 32'(r_valid[0]), 0);
    chk("hold_rdata", r_rdata[0], 32'hDEAD_BEEF);
    // Same-cycle write collision and read-before-write
    setp(0, 1'b1, BASE + 32'h40, 32'h0000_0077, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    req = '0;
    setp(1, 1'b1, BASE + 32'h40, 32'h0000_0001, 4'hF, 32'h0, 1'b0);
    setp(3, 1'b1, BASE + 32'h40, 32'h0000_0003, 4'hF, 32'h0, 1'b0);
    setp(0, 1'b0, BASE + 32'h40, 32'h0, 4'hF, 32'h0000_0077, 1'b0);
    @(negedge clk);
    req = '0;
    setp(2, 1'b0, BASE + 32'h40, 32'h0, 4'hF, 32'h0000_0003, 1'b0);
    @(negedge clk);
    req = '0;
    setp(1, 1'b1, BASE + 32'h44, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0);
    setp(3, 1'b1, BASE + 32'h44, 32'h0000_1122, 4'h3, 32'h0, 1'b0);
    @(negedge clk);
    req = '0;
    setp(0, 1'b0, BASE + 32'h44, 32'h0, 4'hF, 32'hAABB_1122, 1'b0);
    @(negedge clk);
    req = '0;
    // Held request under maximal stall threshold
    stall_thr = 8'hFF;
    setp(1, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
`ifdef TCDM_MEM_STALL_EN
    ng = 0; gap = 0; maxgap = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (gnt[1]) begin ng++; gap = 0; end
      else begin gap++; if (gap > maxgap) maxgap = gap; end
      @(negedge clk);
    end
    chk("stall_max_gap", 32'(maxgap), 32'd7);
    chk("stall_some_gnt", 32'(ng >= 5), 32'd1);
`else
    for (int c = 0; c < 10; c++) begin
      #1 chk($sformatf("nostall_gnt_c%0d", c), 32'(gnt[1]), 32'd1);
      @(negedge clk);
    end
`endif
    req = '0;
    stall_thr = 8'h00;
    repeat (3) @(negedge clk);
    // Latency-4 instance: write, readback, then reset mid-flight
    req4 = 1'b1; wen4 = 1'b0; addr4[0] = BASE; wdata4[0] = 32'hCAFE_F00D; be4[0] = 4'hF;
    lat4(32'h0);
    @(negedge clk);
    req4 = 1'b1; wen4 = 1'b1; addr4[0] = BASE;
    lat4(32'hCAFE_F00D);
    @(negedge clk);
    req4 = 1'b1; wen4 = 1'b1; addr4[0] = BASE;
    @(negedge clk);
    addr4[0] = BASE + 32'h4;
    @(negedge clk);
    addr4[0] = BASE + 32'h8;
    @(negedge clk);
    req4 = '0;
    rst4_n = 1'b0;
    #1 chk("l4_rst_valid", 32'(rv4), 0);
    repeat (2) @(negedge clk);
    rst4_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("l4_post_rst_k%0d", k), {30'b0, rv4, opc4}, 0);
      if (k == 0) chk("l4_post_rst_rdata", rd4[0], 0);
    end
    req4 = 1'b1; wen4 = 1'b1; addr4[0] = BASE;
    lat4(32'h0);
    repeat (3) @(negedge clk);
    for (int p = 0; p < NP; p++) chk($sformatf("drain_p%0d", p), 32'(exp_q[p].size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
